// File: rtl/bus_dispatcher.sv
// Broadcasts one packet to all caster columns and collects column psums round-robin.
// Latency: packet on bus 1 cycle after accept, collected psum on out_data 1 cycle after grant.
// Backpressure: in_ready low until every column accepts or the wait expires; out_data held while out_ready is low.
module bus_dispatcher #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_type,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    input  logic [2*DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]           ifmap_data_B2M,
    output logic [DATA_WIDTH-1:0]           fltr_data_B2M,
    output logic [2*DATA_WIDTH-1:0]         psum_data_B2M,
    output logic [2:0]                      caster_en,
    output logic [TAG_WIDTH-1:0]            tag,
    input  logic [NUM_COL-1:0]              caster_ready,
    input  logic [NUM_COL-1:0]              caster_valid,
    input  logic [NUM_COL*2*DATA_WIDTH-1:0] psum_data_M2B,
    output logic [NUM_COL-1:0]              caster_ack,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_COL)-1:0]      out_col,
    output logic                            err
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(NUM_COL);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BCAST} state_t;

    state_t            st, st_nxt;
    logic [1:0]        typ_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [PW-1:0]     data_q;
    logic [TW-1:0]     cnt;
    logic              err_q;
    logic              accept, all_rdy, drop, expired;

    assign accept  = in_valid && in_ready;
    assign all_rdy = &caster_ready;
    assign drop    = accept && (in_type == 2'd3);
    assign expired = (st == BCAST) && !all_rdy && (cnt == TW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (accept && in_type != 2'd3) st_nxt = BCAST;
            BCAST:   if (all_rdy || expired)        st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // in_ready is gated by rstn so every output reads 0 while reset is held
    always_comb begin
        in_ready       = rstn && (st == IDLE);
        caster_en      = 3'b000;
        tag            = '0;
        ifmap_data_B2M = '0;
        fltr_data_B2M  = '0;
        psum_data_B2M  = '0;
        if (st == BCAST) begin
            tag = tag_q;
            case (typ_q)
                2'd0: begin caster_en = 3'b001; ifmap_data_B2M = data_q[DATA_WIDTH-1:0]; end
                2'd1: begin caster_en = 3'b010; fltr_data_B2M  = data_q[DATA_WIDTH-1:0]; end
                2'd2: begin caster_en = 3'b100; psum_data_B2M  = data_q; end
                default: caster_en = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            typ_q  <= '0;
            tag_q  <= '0;
            data_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= drop || expired;
            cnt   <= (st == BCAST) ? cnt + 1'b1 : '0;
            if (accept) begin
                typ_q  <= in_type;
                tag_q  <= in_tag;
                data_q <= in_data;
            end
        end
    end

    logic [PW-1:0] col_psum [NUM_COL];
    logic [CW-1:0] rr, gnt_idx, scan_idx;
    logic          take, gnt_vld;

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        assign col_psum[c] = psum_data_M2B[c*PW +: PW];
    end

    assign take = !out_valid || out_ready;

    // scan starts at rr so the column after the last winner has top priority
    always_comb begin
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        scan_idx   = '0;
        caster_ack = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            scan_idx = CW'((int'(rr) + i) % NUM_COL);
            if (!gnt_vld && caster_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (rstn && take && gnt_vld) caster_ack[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
        end else if (take && gnt_vld) begin
            out_valid <= 1'b1;
            out_data  <= col_psum[gnt_idx];
            out_col   <= gnt_idx;
            rr        <= (gnt_idx == CW'(NUM_COL - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_dispatcher.sv
module tb_bus_dispatcher;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int TGW = 4;
    localparam int TO = 64;
    localparam int PW = 2 * DW;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid, in_ready;
    logic [1:0]        in_type;
    logic [TGW-1:0]    in_tag;
    logic [PW-1:0]     in_data;
    logic [DW-1:0]     ifmap_data_B2M, fltr_data_B2M;
    logic [PW-1:0]     psum_data_B2M;
    logic [2:0]        caster_en;
    logic [TGW-1:0]    tag;
    logic [NC-1:0]     caster_ready, caster_valid, caster_ack;
    logic [NC*PW-1:0]  psum_data_M2B;
    logic              out_valid, out_ready, err;
    logic [PW-1:0]     out_data;
    logic [1:0]        out_col;

    bus_dispatcher #(.DATA_WIDTH(DW), .NUM_COL(NC), .TAG_WIDTH(TGW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_tag(in_tag), .in_data(in_data), .ifmap_data_B2M(ifmap_data_B2M),
        .fltr_data_B2M(fltr_data_B2M), .psum_data_B2M(psum_data_B2M), .caster_en(caster_en),
        .tag(tag), .caster_ready(caster_ready), .caster_valid(caster_valid),
        .psum_data_M2B(psum_data_M2B), .caster_ack(caster_ack), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_col(out_col), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a packet is either on the bus or not; results sit in one slot.
    bit         m_busy, m_err, m_ov;
    int         m_age, m_rr, m_ocol, g;
    logic [1:0] m_type;
    logic [TGW-1:0] m_tag;
    logic [PW-1:0]  m_data, m_odata;
    bit         e;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_caster_en", caster_en, 0);
            check("rst_tag", tag, 0);
            check("rst_buses", {ifmap_data_B2M, fltr_data_B2M, psum_data_B2M}, 0);
            check("rst_ack", caster_ack, 0);
            check("rst_out", {out_valid, out_col, out_data}, 0);
            check("rst_err", err, 0);
            m_busy = 0; m_err = 0; m_ov = 0; m_age = 0; m_rr = 0; m_ocol = 0;
            m_odata = 0; m_type = 0; m_tag = 0; m_data = 0;
        end else begin
            g = -1;
            if (!m_ov || out_ready)
                for (int i = 0; i < NC; i++)
                    if (g < 0 && caster_valid[(m_rr + i) % NC]) g = (m_rr + i) % NC;
            check("m_in_ready", in_ready, !m_busy);
            check("m_caster_en", caster_en, m_busy ? (3'b001 << m_type) : 3'b000);
            check("m_tag", tag, m_busy ? m_tag : 0);
            check("m_ifmap", ifmap_data_B2M, (m_busy && m_type == 0) ? m_data[DW-1:0] : 0);
            check("m_fltr", fltr_data_B2M, (m_busy && m_type == 1) ? m_data[DW-1:0] : 0);
            check("m_psum", psum_data_B2M, (m_busy && m_type == 2) ? m_data : 0);
            check("m_err", err, m_err);
            check("m_ack", caster_ack, (g >= 0) ? (4'b0001 << g) : 4'b0000);
            check("m_out_valid", out_valid, m_ov);
            check("m_out_data", out_data, m_odata);
            check("m_out_col", out_col, m_ocol);
            e = 0;
            if (m_busy) begin
                if (caster_ready == 4'hF) m_busy = 0;
                else begin
                    m_age++;
                    if (m_age == TO) begin m_busy = 0; e = 1; end
                end
            end else if (in_valid) begin
                m_type = in_type; m_tag = in_tag; m_data = in_data;
                if (in_type == 2'd3) e = 1;
                else begin m_busy = 1; m_age = 0; end
            end
            m_err = e;
            if (g >= 0) begin
                m_ov = 1; m_odata = psum_data_M2B[g*PW +: PW]; m_ocol = g; m_rr = (g + 1) % NC;
            end else if (out_ready) m_ov = 0;
        end
    end

    int n, ne, nen, nrdy;
    logic [NC-1:0] acks [5];
    logic [NC-1:0] exp_ack [5];
    logic [PW-1:0] cdat [4];

    initial begin
        rstn = 0; in_valid = 0; in_type = 0; in_tag = 0; in_data = 0;
        caster_ready = 0; caster_valid = 0; psum_data_M2B = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check("lit_rst_in_ready", in_ready, 0);
        check("lit_rst_out_valid", out_valid, 0);
        @(posedge clk); #1 rstn = 1;
        @(negedge clk);
        check("lit_post_rst_in_ready", in_ready, 1);

        // ifmap with immediate acceptance
        @(posedge clk); #1;
        in_valid = 1; in_type = 0; in_tag = 3; in_data = 32'h0000_00AB; caster_ready = 4'hF;
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        check("lit_ifmap_en", caster_en, 3'b001);
        check("lit_ifmap_tag", tag, 3);
        check("lit_ifmap_bus", ifmap_data_B2M, 16'h00AB);
        check("lit_ifmap_fltr_zero", fltr_data_B2M, 0);
        check("lit_ifmap_busy", in_ready, 0);
        @(negedge clk);
        check("lit_ifmap_en_drop", caster_en, 0);
        check("lit_ifmap_ready_back", in_ready, 1);

        // psum with one column late for 5 cycles
        @(posedge clk); #1;
        in_valid = 1; in_type = 2; in_tag = 5; in_data = 32'h1234_5678; caster_ready = 4'h7;
        @(posedge clk); #1 in_valid = 0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) caster_ready = 4'hF;
            @(negedge clk);
            if (i == 1) check("lit_psum_bus", psum_data_B2M, 32'h1234_5678);
            if (caster_en == 3'b100) n++;
            @(posedge clk); #1;
        end
        check("lit_psum_en_cycles", n, 6);

        // reserved type is dropped with a single err pulse
        in_valid = 1; in_type = 3; in_tag = 1; in_data = 32'hDEAD_BEEF;
        ne = 0; nen = 0; nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ne += int'(err); nen += int'(caster_en != 0); nrdy += int'(in_ready);
            @(posedge clk); #1 in_valid = 0;
        end
        check("lit_rsv_err_pulses", ne, 1);
        check("lit_rsv_en_cycles", nen, 0);
        check("lit_rsv_ready_cycles", nrdy, 6);

        // fltr never accepted -> timeout
        in_valid = 1; in_type = 1; in_tag = 9; in_data = 32'h0000_BEEF; caster_ready = 4'h0;
        @(posedge clk); #1 in_valid = 0;
        n = 0; ne = 0;
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            if (i == 0) check("lit_fltr_bus", fltr_data_B2M, 16'hBEEF);
            n += int'(caster_en == 3'b010); ne += int'(err);
            @(posedge clk); #1;
        end
        check("lit_timeout_en_cycles", n, 64);
        check("lit_timeout_err_pulses", ne, 1);

        // round-robin with every column valid
        cdat[0] = 32'hC0C0_0000; cdat[1] = 32'hC1C1_0001; cdat[2] = 32'hC2C2_0002; cdat[3] = 32'hC3C3_0003;
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100; exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
        caster_ready = 4'hF; caster_valid = 4'hF; out_ready = 1;
        psum_data_M2B = {cdat[3], cdat[2], cdat[1], cdat[0]};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acks[i] = caster_ack;
            if (i > 0) begin
                check("lit_rr_out_col", out_col, i - 1);
                check("lit_rr_out_data", out_data, cdat[i-1]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) check("lit_rr_ack", acks[i], exp_ack[i]);
        caster_valid = 0;

        // reset in the middle of a broadcast with a result pending
        out_ready = 0; caster_valid = 4'hF; caster_ready = 0;
        in_valid = 1; in_type = 0; in_tag = 7; in_data = 32'h1;
        @(posedge clk); #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("lit_mid_pre_valid", out_valid, 1);
        check("lit_mid_pre_en", caster_en, 3'b001);
        rstn = 0; #1;
        check("lit_mid_en_zero", caster_en, 0);
        check("lit_mid_out_zero", {out_valid, out_col, out_data}, 0);
        check("lit_mid_tag_bus_zero", {tag, ifmap_data_B2M}, 0);
        @(posedge clk); #1 rstn = 1;
        @(negedge clk);
        check("lit_mid_in_ready", in_ready, 1);
        check("lit_mid_rr_col0", caster_ack, 4'b0001);
        @(posedge clk); #1;
        caster_valid = 0; caster_ready = 4'hF; out_ready = 1;

        for (int k = 0; k < 4000; k++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_type       = 2'($urandom_range(0, 3));
            in_tag        = 4'($urandom);
            in_data       = $urandom;
            caster_ready  = ((k % 700) < 80) ? 4'h0 : (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF);
            caster_valid  = 4'($urandom);
            out_ready     = ($urandom_range(0, 3) != 0);
            psum_data_M2B = {$urandom, $urandom, $urandom, $urandom};
            if (!rstn) rstn = 1;
            else if ($urandom_range(0, 499) == 0) rstn = 0;
            @(posedge clk); #1;
        end
        rstn = 1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
